// File: rtl/lz77_decoder.sv
// LZ77 token decoder: rebuilds the byte stream from (distance, length, literal) tokens.
// Optional LZ77_DECODER_STATS_EN adds byte_count / token_count outputs.
module lz77_decoder #(
    parameter int unsigned DATA_WIDTH            = 8,
    parameter int unsigned DICTIONARY_DEPTH      = 32,
    parameter int unsigned DICTIONARY_DEPTH_LOG  = $clog2(DICTIONARY_DEPTH),
    parameter int unsigned LOOK_AHEAD_BUFF_DEPTH = 19,
    parameter int unsigned CNT_WIDTH             = $clog2(LOOK_AHEAD_BUFF_DEPTH)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            tok_valid,
    output logic                            tok_ready,
    input  logic [DICTIONARY_DEPTH_LOG-1:0] match_position,
    input  logic [CNT_WIDTH-1:0]            match_length,
    input  logic [DATA_WIDTH-1:0]           next_symbol,
    output logic [DATA_WIDTH-1:0]           out_data,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic                            dist_err
`ifdef LZ77_DECODER_STATS_EN
   ,output logic [31:0]                     byte_count,
    output logic [31:0]                     token_count
`endif
);

    localparam int unsigned PTR_W  = DICTIONARY_DEPTH_LOG;
    localparam int unsigned FILL_W = DICTIONARY_DEPTH_LOG + 1;

    typedef enum logic [1:0] {IDLE, COPY, LIT} state_t;

    state_t                  state_q, state_d;
    logic                    tok_ready_q, tok_ready_d;
    logic                    out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0]   out_data_q, out_data_d;
    logic                    dist_err_q, dist_err_d;
    logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
    logic [FILL_W-1:0]       fill_q, fill_d;
    logic [CNT_WIDTH-1:0]    remaining_q, remaining_d;
    logic [DATA_WIDTH-1:0]   sym_q, sym_d;
    logic [DATA_WIDTH-1:0]   dict_q [DICTIONARY_DEPTH];

    logic                    slot_free;
    logic                    accept;
    logic                    bad_dist;
    logic                    issue;
    logic [DATA_WIDTH-1:0]   issue_data;

    assign slot_free = !out_valid_q || out_ready;
    assign accept    = tok_valid && tok_ready_q;
    assign bad_dist  = (match_position == '0) || (FILL_W'(match_position) > fill_q);

    // Next-state and datapath; a byte is issued whenever it is loaded into the output slot.
    always_comb begin
        state_d     = state_q;
        rd_ptr_d    = rd_ptr_q;
        remaining_d = remaining_q;
        sym_d       = sym_q;
        dist_err_d  = dist_err_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q && !out_ready;
        wr_ptr_d    = wr_ptr_q;
        fill_d      = fill_q;
        issue       = 1'b0;
        issue_data  = '0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    sym_d       = next_symbol;
                    rd_ptr_d    = wr_ptr_q - match_position;
                    remaining_d = match_length;
                    if (match_length == '0) begin
                        state_d = LIT;
                    end else if (bad_dist) begin
                        dist_err_d  = 1'b1;
                        remaining_d = '0;
                        state_d     = LIT;
                    end else begin
                        state_d = COPY;
                    end
                end
            end
            COPY: begin
                // Dictionary is read combinationally, so distance-1 copies see last cycle's write.
                if (slot_free) begin
                    issue       = 1'b1;
                    issue_data  = dict_q[rd_ptr_q];
                    rd_ptr_d    = rd_ptr_q + PTR_W'(1);
                    remaining_d = remaining_q - CNT_WIDTH'(1);
                    if (remaining_q == CNT_WIDTH'(1)) begin
                        state_d = LIT;
                    end
                end
            end
            LIT: begin
                if (slot_free) begin
                    issue      = 1'b1;
                    issue_data = sym_q;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (issue) begin
            out_valid_d = 1'b1;
            out_data_d  = issue_data;
            wr_ptr_d    = wr_ptr_q + PTR_W'(1);
            if (fill_q != FILL_W'(DICTIONARY_DEPTH)) begin
                fill_d = fill_q + FILL_W'(1);
            end
        end
        tok_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            tok_ready_q <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            dist_err_q  <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            fill_q      <= '0;
            remaining_q <= '0;
            sym_q       <= '0;
        end else begin
            state_q     <= state_d;
            tok_ready_q <= tok_ready_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            dist_err_q  <= dist_err_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            fill_q      <= fill_d;
            remaining_q <= remaining_d;
            sym_q       <= sym_d;
        end
    end

    // Sliding dictionary storage; contents survive reset.
    always_ff @(posedge clk) begin
        if (issue) begin
            dict_q[wr_ptr_q] <= issue_data;
        end
    end

    assign tok_ready = tok_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign dist_err  = dist_err_q;

`ifdef LZ77_DECODER_STATS_EN
    logic [31:0] byte_count_q, byte_count_d;
    logic [31:0] token_count_q, token_count_d;

    always_comb begin
        byte_count_d  = byte_count_q;
        token_count_d = token_count_q;
        if (out_valid_q && out_ready) begin
            byte_count_d = byte_count_q + 32'd1;
        end
        if (accept) begin
            token_count_d = token_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byte_count_q  <= '0;
            token_count_q <= '0;
        end else begin
            byte_count_q  <= byte_count_d;
            token_count_q <= token_count_d;
        end
    end

    assign byte_count  = byte_count_q;
    assign token_count = token_count_q;
`endif

endmodule

// File: tb/tb_lz77_decoder.sv
// Self-checking bench for lz77_decoder: history-list reference model plus directed and random tokens.
module tb_lz77_decoder;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       tok_valid = 1'b0;
    logic       tok_ready;
    logic [4:0] match_position = '0;
    logic [4:0] match_length = '0;
    logic [7:0] next_symbol = '0;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic       dist_err;
`ifdef LZ77_DECODER_STATS_EN
    logic [31:0] byte_count;
    logic [31:0] token_count;
`endif

    lz77_decoder dut (
        .clk            (clk),
        .rst            (rst),
        .tok_valid      (tok_valid),
        .tok_ready      (tok_ready),
        .match_position (match_position),
        .match_length   (match_length),
        .next_symbol    (next_symbol),
        .out_data       (out_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .dist_err       (dist_err)
`ifdef LZ77_DECODER_STATS_EN
       ,.byte_count     (byte_count),
        .token_count    (token_count)
`endif
    );

    always #5 clk = ~clk;

    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;
    int          nbeats = 0;
    int          acc_cyc = 0;
    int          fill_m = 0;
    bit          exp_err = 1'b0;
    int          rdy_mode = 0;
    bit          prev_hold = 1'b0;
    logic [7:0]  prev_data = '0;
    byte unsigned exp_q[$];
    byte unsigned hist[$];
    byte unsigned got_q[$];
    int          beat_cycs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic check_got(input string name, input string want);
        string s = "";
        foreach (got_q[i]) s = $sformatf("%s%c", s, got_q[i]);
        tests++;
        if (s != want) begin
            fails++;
            $display("FAIL %s: got \"%s\", want \"%s\"", name, s, want);
        end
    endtask

    // Reference model: output = copy of history bytes, then the literal.
    task automatic model_token(input int pos, input int len, input byte unsigned sym);
        byte unsigned b;
        int emitted = 1;
        if (len > 0 && (pos == 0 || pos > fill_m)) begin
            exp_err = 1'b1;
        end else begin
            for (int i = 0; i < len; i++) begin
                b = hist[hist.size() - pos];
                hist.push_back(b);
                exp_q.push_back(b);
            end
            emitted += len;
        end
        hist.push_back(sym);
        exp_q.push_back(sym);
        fill_m = (fill_m + emitted > 32) ? 32 : fill_m + emitted;
        while (hist.size() > 64) void'(hist.pop_front());
    endtask

    task automatic clear_model();
        exp_q.delete();
        hist.delete();
        fill_m  = 0;
        exp_err = 1'b0;
    endtask

    // Stream checker: every handshake compared to the model, stalls must hold data.
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (rst) begin
            prev_hold = 1'b0;
        end else begin
            if (prev_hold) begin
                check("hold_valid", 32'(out_valid), 32'd1);
                check("hold_data", 32'(out_data), 32'(prev_data));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_byte: got %0h, want none", out_data);
                end else begin
                    check("stream", 32'(out_data), 32'(exp_q.pop_front()));
                end
                got_q.push_back(out_data);
                beat_cycs.push_back(cyc);
                nbeats++;
            end
            check("dist_err", 32'(dist_err), 32'(exp_err));
            prev_hold = out_valid && !out_ready;
            prev_data = out_data;
        end
    end

    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = ($urandom_range(0, 3) != 0);
            default: out_ready = ~out_ready;
        endcase
    end

    task automatic send(input int pos, input int len, input logic [7:0] sym);
        int b = 0;
        @(posedge clk);
        #1;
        tok_valid      = 1'b1;
        match_position = 5'(pos);
        match_length   = 5'(len);
        next_symbol    = sym;
        @(negedge clk);
        while (!tok_ready && b < 200) begin
            @(negedge clk);
            b++;
        end
        if (!tok_ready) begin
            tests++;
            fails++;
            $display("FAIL tok_accept: got tok_ready=0 for 200 cycles, want 1");
            tok_valid = 1'b0;
            return;
        end
        @(posedge clk);
        acc_cyc = cyc;
        model_token(pos, len, sym);
        #1 tok_valid = 1'b0;
    endtask

    task automatic wait_beats_to(input int target);
        int b = 0;
        while (nbeats < target && b < 500) begin
            @(negedge clk);
            #2;
            b++;
        end
        if (nbeats < target) begin
            tests++;
            fails++;
            $display("FAIL wait_beats: got %0d beats, want %0d", nbeats, target);
        end
    endtask

    task automatic release_reset();
        @(posedge clk);
        #1 rst = 1'b0;
        check("tok_ready_at_release", 32'(tok_ready), 32'd0);
        @(posedge clk);
        #1 check("tok_ready_after_rst", 32'(tok_ready), 32'd1);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        clear_model();
        @(negedge clk);
        check("rst_tok_ready", 32'(tok_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_dist_err", 32'(dist_err), 32'd0);
        release_reset();
    endtask

    task automatic send_wiki();
        int t;
        got_q.delete();
        t = nbeats + 16;
        send(0, 0, "a");
        send(1, 1, "c");
        send(3, 4, "b");
        send(3, 3, "a");
        send(12, 3, "$");
        wait_beats_to(t);
    endtask

    task automatic drain();
        int b = 0;
        while (exp_q.size() != 0 && b < 2000) begin
            @(negedge clk);
            #2;
            b++;
        end
        check("drain", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        do_reset();

        // single literal: one byte, one cycle, two falling edges after the accepting edge
        rdy_mode = 0;
        got_q.delete();
        beat_cycs.delete();
        t = nbeats + 1;
        send(0, 0, "a");
        wait_beats_to(t);
        check("lit_latency", 32'(beat_cycs[0]), 32'(acc_cyc + 2));
        check_got("lit_data", "a");
        @(negedge clk);
        #2 check("lit_one_cycle", 32'(out_valid), 32'd0);
        check("lit_no_err", 32'(dist_err), 32'd0);

        // distance-1 run: 15 copies plus literal, no gaps
        beat_cycs.delete();
        t = nbeats + 16;
        send(1, 15, "$");
        wait_beats_to(t);
        check_got("run_data", "aaaaaaaaaaaaaaaa$");
        check("run_beats", 32'(beat_cycs.size()), 32'd16);
        check("run_first", 32'(beat_cycs[0]), 32'(acc_cyc + 2));
        check("run_last", 32'(beat_cycs[15]), 32'(acc_cyc + 17));

        send_wiki();
        check_got("wiki", "aacaacabcabaaac$");

        rdy_mode = 2;
        send_wiki();
        check_got("wiki_bp", "aacaacabcabaaac$");

        // random legal tokens under random backpressure
        rdy_mode = 1;
        for (int k = 0; k < 150; k++) begin
            int pos;
            int len;
            if (fill_m == 0) begin
                pos = 0;
                len = 0;
            end else begin
                pos = $urandom_range(1, (fill_m < 31) ? fill_m : 31);
                len = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 18);
            end
            send(pos, len, 8'($urandom));
        end
        drain();

        // distance larger than fill: copy skipped, flag sticky
        rdy_mode = 0;
        do_reset();
        got_q.delete();
        t = nbeats + 3;
        send(0, 0, "p");
        send(0, 0, "q");
        send(5, 3, "x");
        wait_beats_to(t);
        check_got("bad_dist_data", "pqx");
        check("bad_dist_flag", 32'(dist_err), 32'd1);
        t = nbeats + 3;
        send(1, 2, "y");
        wait_beats_to(t);
        check_got("after_bad", "pqxxxy");
        check("bad_dist_sticky", 32'(dist_err), 32'd1);

        // distance equal to fill is legal
        do_reset();
        got_q.delete();
        t = nbeats + 5;
        send(0, 0, "p");
        send(0, 0, "q");
        send(2, 2, "r");
        wait_beats_to(t);
        check_got("dist_eq_fill", "pqpqr");
        check("dist_eq_fill_err", 32'(dist_err), 32'd0);

        // reset while the third copy byte sits in the output slot
        do_reset();
        t = nbeats + 1;
        send(0, 0, "a");
        wait_beats_to(t);
        t = nbeats + 2;
        send(1, 15, "$");
        wait_beats_to(t);
        @(posedge clk);
        #2 rst = 1'b1;
        clear_model();
        #1;
        check("async_rst_valid", 32'(out_valid), 32'd0);
        check("async_rst_ready", 32'(tok_ready), 32'd0);
        release_reset();
        got_q.delete();
        t = nbeats + 1;
        send(0, 0, "z");
        wait_beats_to(t);
        check_got("post_rst", "z");
        check("post_rst_err", 32'(dist_err), 32'd0);
`ifdef LZ77_DECODER_STATS_EN
        @(posedge clk);
        #1;
        check("byte_count", byte_count, 32'd1);
        check("token_count", token_count, 32'd1);
`endif
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/lz77_decoder.md
Name: lz77_decoder

Overview:
Downstream stage of lz77_encoder. Consumes (match_position, match_length, next_symbol) tokens and rebuilds the original byte stream in a private sliding dictionary. Emits one byte per cycle on a valid/ready output. Serves as the golden-model consumer in loopback tests and as the decompression path.

Parameters:
DATA_WIDTH, 8, symbol width in bits
DICTIONARY_DEPTH, 32, sliding dictionary entries; must match the encoder
DICTIONARY_DEPTH_LOG, $clog2(DICTIONARY_DEPTH), width of position and pointer fields
LOOK_AHEAD_BUFF_DEPTH, 19, maximum match length the encoder can produce
CNT_WIDTH, $clog2(LOOK_AHEAD_BUFF_DEPTH), width of the length field

Ports:
clk  in  1  clock; one clock domain, all logic on its rising edge
rst  in  1  reset; asynchronous and active-high
tok_valid  in  1  token present
tok_ready  out  1  token accepted when tok_valid && tok_ready
match_position  in  DICTIONARY_DEPTH_LOG  back-distance of the match (1..DICTIONARY_DEPTH-1); 0 = no match
match_length  in  CNT_WIDTH  bytes to copy; 0 = literal only
next_symbol  in  DATA_WIDTH  literal emitted after the copy
out_data  out  DATA_WIDTH  reconstructed byte
out_valid  out  1  out_data valid
out_ready  in  1  consumer accepts when out_valid && out_ready
dist_err  out  1  sticky flag: illegal distance seen

Behaviour:
- Reset values: tok_ready=0, out_valid=0, out_data=0, dist_err=0, wr_ptr=0, fill=0, state=IDLE. Dictionary contents are not reset.
- Reset asserted mid-copy aborts the token immediately. tok_ready=1 on the first clk edge after rst deasserts.
- Output slot is free when !out_valid || out_ready. A byte is "issued" when loaded into the slot. On issue: write the byte to dict[wr_ptr], increment wr_ptr (wraps modulo DICTIONARY_DEPTH), increment fill (saturates at DICTIONARY_DEPTH).
- States:
  - IDLE: tok_ready=1 only while in IDLE. On accept, latch the token, set rd_ptr = wr_ptr - match_position (mod depth), remaining = match_length.
    - remaining > 0 -> COPY.
    - remaining = 0 -> LIT.
  - COPY: each cycle the slot is free, issue dict[rd_ptr], then rd_ptr++ and remaining--. When the last copy byte issues -> LIT.
  - LIT: when the slot is free, issue next_symbol -> IDLE.
- Overlapping copies are legal (match_position < match_length). Copy reads must see the bytes written by earlier cycles of the same token, e.g. distance 1 repeats the last byte.
  - When rd_ptr equals the slot currently being written, forward the write data to the read.
- Illegal token: match_length > 0 with match_position = 0, or match_position > fill. Action: set dist_err (cleared only by rst), skip the copy, go straight to LIT.
- Latency: first byte of a token is valid the cycle after acceptance. With out_ready held at 1, a token produces exactly match_length+1 bytes on consecutive cycles. There is one idle bubble cycle between tokens while back in IDLE.
- Backpressure: while out_valid && !out_ready, out_data and all pointers are held stable.
- Width: match_length is up to LOOK_AHEAD_BUFF_DEPTH-1. remaining uses CNT_WIDTH bits. The pointer subtraction is modulo 2^DICTIONARY_DEPTH_LOG, so DICTIONARY_DEPTH must be a power of two.

Optional Feature:
LZ77_DECODER_STATS_EN:
- Defined: adds output byte_count (32 bits, reset 0), incremented once per out_valid && out_ready handshake and wrapping at 2^32. Adds output token_count (32 bits, reset 0), incremented per accepted token.
- Undefined: neither port nor counter exists.

Test Plan:
- Literal: token (0,0,"a") with out_ready=1 -> out_data="a" one cycle after acceptance, out_valid for exactly one cycle, dist_err=0.
- Run-length overlap: tokens (0,0,"a") then (1,15,"$") -> 16 bytes "a" then "$" (17 bytes total), no gaps inside the second token.
- Wikipedia string: tokens (0,0,"a"), (1,1,"c"), (3,4,"b"), (3,3,"a"), (12,3,"$") -> output "aacaacabcabaaac$".
- Backpressure: during (3,4,"b"), toggle out_ready 1/0 on alternate cycles -> each byte held stable while stalled, sequence unchanged, no duplicate or dropped bytes.
- Illegal distance: after 2 bytes have been emitted, send (5,3,"x") -> dist_err=1, only "x" emitted; dist_err stays 1 until rst.
- Reset mid-copy: assert rst during the 3rd copy byte of (1,15,"$") -> out_valid=0 asynchronously; after release, (0,0,"z") -> "z" with dist_err=0. With LZ77_DECODER_STATS_EN, byte_count=1.
